// File: rtl/core.sv
// Single-cycle RV32I core with a unified byte-addressed instruction/data memory.
// Fetch, execute, memory access and writeback all complete on one rising clk edge.

module core_mem #(
   parameter int MEM_BYTES = 65536
) (
   input  logic        clk_i,
   input  logic [31:0] iaddr_i,
   output logic [31:0] idata_o,
   input  logic [31:0] daddr_i,
   output logic [31:0] ddata_o,
   input  logic [3:0]  dbe_i,
   input  logic [31:0] wdata_i
);
   localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   logic [7:0] m [0:MEM_BYTES-1];

   // Every byte lane wraps on its own, so misaligned words straddling the top wrap too.
   function automatic logic [AW-1:0] wrap(input logic [31:0] base, input int k);
      return AW'((base + 32'(k)) % 32'(MEM_BYTES));
   endfunction

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         idata_o[8*k +: 8] = m[wrap(iaddr_i, k)];
         ddata_o[8*k +: 8] = m[wrap(daddr_i, k)];
      end
   end

   // NOTE: the byte array has no reset; preloaded program contents must survive rst.
   // NOTE: sequential state uses <= so every reader sees the value from before the edge.
   always_ff @(posedge clk_i) begin
      if (dbe_i[0]) m[wrap(daddr_i, 0)] <= wdata_i[7:0];
      if (dbe_i[1]) m[wrap(daddr_i, 1)] <= wdata_i[15:8];
      if (dbe_i[2]) m[wrap(daddr_i, 2)] <= wdata_i[23:16];
      if (dbe_i[3]) m[wrap(daddr_i, 3)] <= wdata_i[31:24];
   end
endmodule

module core #(
   parameter int          MEM_BYTES = 65536,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input logic clk,
   input logic rst
);
   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_OP     = 7'b0110011,
      OP_FENCE  = 7'b0001111,
      OP_SYSTEM = 7'b1110011
   } opcode_e;

   localparam logic [11:0] CSR_MTVEC  = 12'h305;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rs  [0:31];
   logic [31:0] csr [0:4095];

   logic [31:0] instr, dmem_addr, dmem_rdata, load_val;
   logic [3:0]  dmem_be;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        is_store;

   logic        rd_we, csr_we, is_ecall;
   logic [31:0] rd_val, csr_wval, csr_old, csr_src;

   // Writes are suppressed while reset is held so an aborted store leaves memory intact.
   core_mem #(.MEM_BYTES(MEM_BYTES)) memory (
      .clk_i  (clk),
      .iaddr_i(pc_q),
      .idata_o(instr),
      .daddr_i(dmem_addr),
      .ddata_o(dmem_rdata),
      .dbe_i  (rst ? dmem_be : 4'b0000),
      .wdata_i(rs2_val)
   );

   assign rd       = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign csr_addr = instr[31:20];
   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rs[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rs[rs2];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign is_store  = (instr[6:0] == OP_STORE);
   assign dmem_addr = rs1_val + (is_store ? imm_s : imm_i);

   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return alt ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b010:  return {31'd0, $signed(a) < $signed(b)};
         3'b011:  return {31'd0, a < b};
         3'b100:  return a ^ b;
         3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      dmem_be = 4'b0000;
      if (is_store) begin
         case (funct3)
            3'b000:  dmem_be = 4'b0001;
            3'b001:  dmem_be = 4'b0011;
            3'b010:  dmem_be = 4'b1111;
            default: dmem_be = 4'b0000;
         endcase
      end
   end

   always_comb begin
      case (funct3)
         3'b000:  load_val = {{24{dmem_rdata[7]}}, dmem_rdata[7:0]};
         3'b001:  load_val = {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
         3'b100:  load_val = {24'd0, dmem_rdata[7:0]};
         3'b101:  load_val = {16'd0, dmem_rdata[15:0]};
         default: load_val = dmem_rdata;
      endcase
   end

   // NOTE: every output is defaulted first so no path through the case can infer a latch.
   always_comb begin
      pc_d     = pc_q + 32'd4;
      rd_we    = 1'b0;
      rd_val   = 32'd0;
      csr_we   = 1'b0;
      csr_wval = 32'd0;
      is_ecall = 1'b0;
      csr_old  = csr[csr_addr];
      csr_src  = funct3[2] ? {27'd0, rs1} : rs1_val;

      case (opcode_e'(instr[6:0]))
         OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
         OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
         OP_JAL: begin
            rd_we  = 1'b1;
            rd_val = pc_q + 32'd4;
            pc_d   = pc_q + imm_j;
         end
         OP_JALR: begin
            rd_we  = 1'b1;
            rd_val = pc_q + 32'd4;
            pc_d   = (rs1_val + imm_i) & ~32'd1;
         end
         OP_BRANCH: if (branch_taken(funct3, rs1_val, rs2_val)) pc_d = pc_q + imm_b;
         OP_LOAD:   begin rd_we = 1'b1; rd_val = load_val; end
         OP_IMM: begin
            rd_we  = 1'b1;
            rd_val = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_val, imm_i);
         end
         OP_OP:     begin rd_we = 1'b1; rd_val = alu(funct3, instr[30], rs1_val, rs2_val); end
         OP_SYSTEM: begin
            if (funct3 == 3'b000) begin
               if (csr_addr == 12'h000) begin
                  is_ecall = 1'b1;
                  pc_d     = csr[CSR_MTVEC];
               end else if (csr_addr == 12'h302) begin
                  pc_d = csr[CSR_MEPC];
               end
            end else if (funct3 != 3'b100) begin
               rd_we  = 1'b1;
               rd_val = csr_old;
               // Set/clear with a zero source is a pure read and must leave the CSR alone.
               case (funct3[1:0])
                  2'b01:   begin csr_we = 1'b1;        csr_wval = csr_src; end
                  2'b10:   begin csr_we = (rs1 != 0);  csr_wval = csr_old | csr_src; end
                  default: begin csr_we = (rs1 != 0);  csr_wval = csr_old & ~csr_src; end
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
         rs   <= '{default: 32'd0};
         csr  <= '{default: 32'd0};
      end else begin
         pc_q <= pc_d;
         if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
         if (csr_we) csr[csr_addr] <= csr_wval;
         if (is_ecall) begin
            csr[CSR_MEPC]   <= pc_q;
            csr[CSR_MCAUSE] <= 32'd11;
         end
      end
   end
endmodule

// File: tb/tb_core.sv
// Directed bench for core: one instruction per vector, placed at the expected pc,
// then checks the destination register and next pc; plus reset/trap/memory sequences.

module tb_core;
   logic clk;
   logic rst;

   core #(.MEM_BYTES(65536), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk),
      .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          chk_reg;
      logic [31:0] exp_val;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPL = 7'b0000011;
   localparam logic [6:0] OPS = 7'b1110011;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic [31:0] instr, input int r,
                      input logic [31:0] v, input logic [31:0] pc);
      vec_t t;
      t.name = name; t.instr = instr; t.chk_reg = r; t.exp_val = v; t.exp_pc = pc;
      vecs.push_back(t);
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   initial begin
      logic [31:0] pc_m;
      logic        any_nonzero;

      rst = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < 65536; i++) dut.memory.m[i] = 8'h00;

      add("addi_neg1",  enc_i(12'hFFF, 0, 3'b000, 1, OPI),       1,  32'hFFFF_FFFF, 32'h0000_0004);
      add("srli",       enc_i(12'd28, 1, 3'b101, 2, OPI),        2,  32'h0000_000F, 32'h0000_0008);
      add("srai",       enc_i(12'h41C, 1, 3'b101, 3, OPI),       3,  32'hFFFF_FFFF, 32'h0000_000C);
      add("lui",        enc_u(20'h8000B, 4, 7'b0110111),         4,  32'h8000_B000, 32'h0000_0010);
      add("addi_negimm",enc_i(12'hBCD, 4, 3'b000, 4, OPI),       4,  32'h8000_ABCD, 32'h0000_0014);
      add("addi_base",  enc_i(12'h100, 0, 3'b000, 5, OPI),       5,  32'h0000_0100, 32'h0000_0018);
      add("sw",         enc_s(12'd0, 4, 5, 3'b010),              4,  32'h8000_ABCD, 32'h0000_001C);
      add("lhu_hi",     enc_i(12'd2, 5, 3'b101, 6, OPL),         6,  32'h0000_8000, 32'h0000_0020);
      add("lh_hi",      enc_i(12'd2, 5, 3'b001, 7, OPL),         7,  32'hFFFF_8000, 32'h0000_0024);
      add("lb",         enc_i(12'd0, 5, 3'b000, 8, OPL),         8,  32'hFFFF_FFCD, 32'h0000_0028);
      add("lbu",        enc_i(12'd1, 5, 3'b100, 8, OPL),         8,  32'h0000_00AB, 32'h0000_002C);
      add("lw_misalign",enc_i(12'd1, 5, 3'b010, 9, OPL),         9,  32'h0080_00AB, 32'h0000_0030);
      add("sub",        enc_r(7'h20, 1, 5, 3'b000, 10),          10, 32'h0000_0101, 32'h0000_0034);
      add("slt",        enc_r(7'h00, 5, 1, 3'b010, 11),          11, 32'h0000_0001, 32'h0000_0038);
      add("sltu",       enc_r(7'h00, 5, 1, 3'b011, 12),          12, 32'h0000_0000, 32'h0000_003C);
      add("sltiu",      enc_i(12'hFFF, 5, 3'b011, 13, OPI),      13, 32'h0000_0001, 32'h0000_0040);
      add("xori",       enc_i(12'h0F0, 1, 3'b100, 14, OPI),      14, 32'hFFFF_FF0F, 32'h0000_0044);
      add("sll",        enc_r(7'h00, 2, 5, 3'b001, 15),          15, 32'h0080_0000, 32'h0000_0048);
      add("sra",        enc_r(7'h20, 2, 4, 3'b101, 16),          16, 32'hFFFF_0001, 32'h0000_004C);
      add("srl_low5",   enc_r(7'h00, 10, 5, 3'b101, 17),         17, 32'h0000_0080, 32'h0000_0050);
      add("auipc",      enc_u(20'h00001, 18, 7'b0010111),        18, 32'h0000_1050, 32'h0000_0054);
      add("beq_taken",  enc_b(13'd8, 3, 1, 3'b000),              3,  32'hFFFF_FFFF, 32'h0000_005C);
      add("bne_nt",     enc_b(13'd8, 3, 1, 3'b001),              3,  32'hFFFF_FFFF, 32'h0000_0060);
      add("blt_taken",  enc_b(13'd12, 5, 1, 3'b100),             5,  32'h0000_0100, 32'h0000_006C);
      add("bgeu_taken", enc_b(13'd8, 5, 1, 3'b111),              5,  32'h0000_0100, 32'h0000_0074);
      add("jal",        enc_j(21'd16, 19),                       19, 32'h0000_0078, 32'h0000_0084);
      add("jalr",       enc_i(12'h031, 18, 3'b000, 20, 7'b1100111), 20, 32'h0000_0088, 32'h0000_1080);
      add("x0_write",   enc_i(12'd5, 0, 3'b000, 0, OPI),         0,  32'h0000_0000, 32'h0000_1084);
      add("addi_tvec",  enc_i(12'h200, 0, 3'b000, 22, OPI),      22, 32'h0000_0200, 32'h0000_1088);
      add("csrrw",      enc_i(12'h305, 22, 3'b001, 21, OPS),     21, 32'h0000_0000, 32'h0000_108C);
      add("csrrs_x0",   enc_i(12'h305, 0, 3'b010, 23, OPS),      23, 32'h0000_0200, 32'h0000_1090);
      add("csrrsi",     enc_i(12'h305, 5, 3'b110, 24, OPS),      24, 32'h0000_0200, 32'h0000_1094);
      add("csrrci",     enc_i(12'h305, 5, 3'b111, 25, OPS),      25, 32'h0000_0205, 32'h0000_1098);
      add("mhartid",    enc_i(12'hF14, 0, 3'b010, 26, OPS),      26, 32'h0000_0000, 32'h0000_109C);
      add("ecall",      32'h0000_0073,                           26, 32'h0000_0000, 32'h0000_0200);
      add("read_mepc",  enc_i(12'h341, 0, 3'b010, 27, OPS),      27, 32'h0000_109C, 32'h0000_0204);
      add("read_mcause",enc_i(12'h342, 0, 3'b010, 28, OPS),      28, 32'h0000_000B, 32'h0000_0208);
      add("fence",      32'h0000_000F,                           28, 32'h0000_000B, 32'h0000_020C);
      add("ebreak",     32'h0010_0073,                           1,  32'hFFFF_FFFF, 32'h0000_0210);
      add("bad_opcode", 32'h0000_00FF,                           1,  32'hFFFF_FFFF, 32'h0000_0214);
      add("mret",       32'h3020_0073,                           1,  32'hFFFF_FFFF, 32'h0000_109C);

      @(negedge clk);
      check("reset_pc", dut.pc_q, 32'h0000_0000);
      check("reset_x1", dut.rs[1], 32'h0000_0000);
      check("reset_mhartid", dut.csr[12'hF14], 32'h0000_0000);
      rst  = 1'b1;
      pc_m = 32'h0000_0000;

      foreach (vecs[i]) begin
         for (int b = 0; b < 4; b++) dut.memory.m[pc_m + 32'(b)] = vecs[i].instr[8*b +: 8];
         @(negedge clk);
         check({vecs[i].name, "_rd"}, dut.rs[vecs[i].chk_reg], vecs[i].exp_val);
         check({vecs[i].name, "_pc"}, dut.pc_q, vecs[i].exp_pc);
         pc_m = vecs[i].exp_pc;
      end

      check("mepc",     dut.csr[12'h341], 32'h0000_109C);
      check("mcause",   dut.csr[12'h342], 32'h0000_000B);
      check("mtvec",    dut.csr[12'h305], 32'h0000_0200);
      check("mem_100",  {24'd0, dut.memory.m[32'h100]}, 32'h0000_00CD);
      check("mem_103",  {24'd0, dut.memory.m[32'h103]}, 32'h0000_0080);
      check("mem_104",  {24'd0, dut.memory.m[32'h104]}, 32'h0000_0000);

      // Mid-run reset takes effect without a clock edge and spares memory.
      rst = 1'b0;
      #1;
      check("midreset_pc", dut.pc_q, 32'h0000_0000);
      any_nonzero = 1'b0;
      for (int r = 0; r < 32; r++) if (dut.rs[r] != 32'd0) any_nonzero = 1'b1;
      check("midreset_rs_zero", {31'd0, any_nonzero}, 32'h0000_0000);
      check("midreset_mtvec", dut.csr[12'h305], 32'h0000_0000);
      check("midreset_mem", {24'd0, dut.memory.m[32'h100]}, 32'h0000_00CD);

      @(posedge clk);
      #1;
      check("reset_held_pc", dut.pc_q, 32'h0000_0000);
      check("reset_held_x1", dut.rs[1], 32'h0000_0000);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("restart_pc", dut.pc_q, 32'h0000_0004);
      check("restart_x1", dut.rs[1], 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
